// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-timing helpers, frame constants and the
// receiver state encoding. Used by both uart_rx and uart_tx.
package uart_pkg;

    // Frame format: 8 data bits, no parity, 1 stop bit, LSB first.
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Receiver FSM states, exposed on a debug port for checkers.
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    // Clock cycles per line bit (integer divide). Must come out >= 4.
    function automatic int ticks_per_bit(input int clock_speed, input int baud_rate);
        return clock_speed / baud_rate;
    endfunction

    // Offset from the start edge to the middle of the start bit.
    function automatic int half_bit(input int ticks);
        return ticks / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Parallel side of the UART receiver: one-entry output buffer plus
// the framing-error and overrun status pulses.
interface uart_rx_if;
    import uart_pkg::*;

    // Handshake: rx_data is valid and stable while rx_valid=1; the byte is
    // transferred on every rising clk edge where rx_valid=1 and rx_ready=1.
    // rx_ready while rx_valid=0 has no effect. frame_error and overrun are
    // single-cycle status pulses, not part of the handshake.
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_error;
    logic                 overrun;

    // Receiver side drives data and status, consumes ready.
    modport master (
        output rx_data,
        output rx_valid,
        output frame_error,
        output overrun,
        input  rx_ready
    );

    // Consumer side (CPU MMIO / debug logic).
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_error,
        input  overrun,
        output rx_ready
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs. Resets to RESET_VAL so
// an idle-high line does not look like an edge when reset releases.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture of the asynchronous input into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The bit-timing counter restarts on every start edge,
// so each frame is sampled mid-bit regardless of drift in earlier frames.
// Received bytes go to a one-entry valid/ready holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_RATE   = 115200,
    parameter int CLOCK_SPEED = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    uart_rx_if.master  rx,
    output rx_state_t  state_dbg
);

    // TICKS must be >= 4 for the half-bit/full-bit reloads to be meaningful.
    localparam int TICKS = ticks_per_bit(CLOCK_SPEED, BAUD_RATE);
    localparam int HALF  = half_bit(TICKS);
    localparam int CNT_W = $clog2(TICKS);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(TICKS - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    logic                 s_in;
    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 fe_q;
    logic                 ov_q;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (serial_in),
        .q   (s_in)
    );

    // Frame FSM, bit timing, shift register and holding register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            fe_q <= 1'b0;
            ov_q <= 1'b0;

            // Consumer takes the held byte; a same-cycle delivery below wins.
            if (valid_q && rx.rx_ready) begin
                valid_q <= 1'b0;
            end

            case (state)
                RX_IDLE: begin
                    if (!s_in) begin
                        state <= RX_START;
                        cnt   <= HALF_LOAD;
                    end
                end

                RX_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!s_in) begin
                        state   <= RX_DATA;
                        cnt     <= BIT_LOAD;
                        bit_idx <= '0;
                    end else begin
                        // Line went back high by mid-start-bit: a glitch.
                        state <= RX_IDLE;
                    end
                end

                RX_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shift_q[bit_idx] <= s_in;
                        cnt              <= BIT_LOAD;
                        if (bit_idx == LAST_BIT) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end

                RX_STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (s_in) begin
                        state <= RX_IDLE;
                        if (!valid_q || rx.rx_ready) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            ov_q <= 1'b1;
                        end
                    end else begin
                        fe_q  <= 1'b1;
                        state <= RX_BREAK;
                    end
                end

                RX_BREAK: begin
                    // Hold here until the line returns high so a long break
                    // reports a single framing error.
                    if (s_in) begin
                        state <= RX_IDLE;
                    end
                end

                default: state <= RX_IDLE;
            endcase
        end
    end

    assign rx.rx_data     = data_q;
    assign rx.rx_valid    = valid_q;
    assign rx.frame_error = fe_q;
    assign rx.overrun     = ov_q;
    assign state_dbg      = state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit (half bit 8).
module tb_uart_rx;
    import uart_pkg::*;

    localparam int T = 16;

    logic      clk = 1'b0;
    logic      rst = 1'b0;
    logic      serial_in = 1'b1;
    rx_state_t state_dbg;

    uart_rx_if rx_if ();

    uart_rx #(
        .BAUD_RATE   (1),
        .CLOCK_SPEED (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .rx        (rx_if),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    int        rise_cnt = 0;
    int        rise_cyc = 0;
    int        hi_cnt   = 0;
    int        fe_cnt   = 0;
    int        ov_cnt   = 0;
    int        acc_cnt  = 0;
    logic      prev_valid = 1'b0;
    logic [7:0] acc_bytes [0:63];

    always @(negedge clk) begin
        #1;
        if (rst) begin
            if (rx_if.rx_valid && !prev_valid) begin
                rise_cnt = rise_cnt + 1;
                rise_cyc = cyc;
            end
            if (rx_if.rx_valid)    hi_cnt = hi_cnt + 1;
            if (rx_if.frame_error) fe_cnt = fe_cnt + 1;
            if (rx_if.overrun)     ov_cnt = ov_cnt + 1;
            if (rx_if.rx_valid && rx_if.rx_ready) begin
                acc_bytes[acc_cnt[5:0]] = rx_if.rx_data;
                acc_cnt = acc_cnt + 1;
            end
        end
        prev_valid = rx_if.rx_valid;
    end

    // ---------------- scoreboard / checks ----------------
    int         n_asserts = 0;
    int         n_fail    = 0;
    int         rd        = 0;
    int         start_cyc = 0;
    logic [7:0] exp_q [$];
    int         rise0, hi0, fe0, ov0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        rise0 = rise_cnt;
        hi0   = hi_cnt;
        fe0   = fe_cnt;
        ov0   = ov_cnt;
    endtask

    task automatic check_bytes(input string tag);
        logic [7:0] e;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_present"}, 32'(rd < acc_cnt), 32'd1);
            if (rd < acc_cnt) begin
                check({tag, "_data"}, 32'(acc_bytes[rd[5:0]]), 32'(e));
                rd++;
            end
        end
        check({tag, "_no_extra"}, 32'(acc_cnt), 32'(rd));
    endtask

    // ---------------- driver ----------------
    // Called on a falling edge; drives a full frame and returns at its end.
    task automatic send_byte(input logic [7:0] data, input logic stop_bit);
        serial_in = 1'b0;
        start_cyc = cyc;
        repeat (T) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_in = data[i];
            repeat (T) @(negedge clk);
        end
        serial_in = stop_bit;
        repeat (T) @(negedge clk);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rx_if.rx_ready = 1'b0;

        // Reset with line idle high.
        wait_cycles(5);
        check("rst_rx_data",  32'(rx_if.rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_if.rx_valid), 32'd0);
        check("rst_fe",       32'(rx_if.frame_error), 32'd0);
        check("rst_ov",       32'(rx_if.overrun), 32'd0);
        check("rst_state",    32'(state_dbg), 32'(RX_IDLE));
        rst = 1'b1;
        snap();
        wait_cycles(200);
        check("idle_no_valid", 32'(rise_cnt - rise0), 32'd0);
        check("idle_no_fe",    32'(fe_cnt - fe0), 32'd0);
        check("idle_no_ov",    32'(ov_cnt - ov0), 32'd0);
        check("idle_rx_data",  32'(rx_if.rx_data), 32'h00);
        check("idle_state",    32'(state_dbg), 32'(RX_IDLE));

        // 0x55 with consumer ready: one-cycle valid, 155-cycle latency.
        rx_if.rx_ready = 1'b1;
        snap();
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        wait_cycles(20);
        check("b55_latency",  32'(rise_cyc - start_cyc), 32'd155);
        check("b55_rises",    32'(rise_cnt - rise0), 32'd1);
        check("b55_hi_width", 32'(hi_cnt - hi0), 32'd1);
        check("b55_no_fe",    32'(fe_cnt - fe0), 32'd0);
        check_bytes("b55");

        // 4-cycle glitch is rejected, then 0x3C is received.
        snap();
        serial_in = 1'b0;
        wait_cycles(4);
        serial_in = 1'b1;
        wait_cycles(40);
        check("glitch_no_valid", 32'(rise_cnt - rise0), 32'd0);
        check("glitch_no_fe",    32'(fe_cnt - fe0), 32'd0);
        check("glitch_state",    32'(state_dbg), 32'(RX_IDLE));
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        wait_cycles(20);
        check_bytes("b3c");

        // 0xA3 with bad stop bit then a 40-bit break: one framing error.
        snap();
        send_byte(8'hA3, 1'b0);
        wait_cycles(40 * T);
        check("brk_state", 32'(state_dbg), 32'(RX_BREAK));
        serial_in = 1'b1;
        wait_cycles(40);
        check("brk_fe_once",  32'(fe_cnt - fe0), 32'd1);
        check("brk_no_valid", 32'(rise_cnt - rise0), 32'd0);
        check("brk_state_idle", 32'(state_dbg), 32'(RX_IDLE));
        exp_q.push_back(8'hA3);
        send_byte(8'hA3, 1'b1);
        wait_cycles(20);
        check_bytes("ba3");

        // Consumer stalled: 0x12 held, back-to-back 0x34 overruns.
        rx_if.rx_ready = 1'b0;
        snap();
        exp_q.push_back(8'h12);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        wait_cycles(20);
        check("ovr_valid",  32'(rx_if.rx_valid), 32'd1);
        check("ovr_data",   32'(rx_if.rx_data), 32'h12);
        check("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
        check("ovr_no_fe",  32'(fe_cnt - fe0), 32'd0);
        rx_if.rx_ready = 1'b1;
        wait_cycles(1);
        rx_if.rx_ready = 1'b0;
        wait_cycles(3);
        check("ovr_cleared", 32'(rx_if.rx_valid), 32'd0);
        check_bytes("b12");

        // Reset after 4 data bits of 0xFF, then 0xF0 is received cleanly.
        rx_if.rx_ready = 1'b1;
        serial_in = 1'b0;
        wait_cycles(T);
        serial_in = 1'b1;
        wait_cycles(4 * T);
        check("mid_state_data", 32'(state_dbg), 32'(RX_DATA));
        rst = 1'b0;
        wait_cycles(3);
        check("mid_rst_data",  32'(rx_if.rx_data), 32'h00);
        check("mid_rst_valid", 32'(rx_if.rx_valid), 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'(RX_IDLE));
        rst = 1'b1;
        wait_cycles(200);
        snap();
        exp_q.push_back(8'hF0);
        send_byte(8'hF0, 1'b1);
        wait_cycles(20);
        check("bf0_no_fe",   32'(fe_cnt - fe0), 32'd0);
        check("bf0_latency", 32'(rise_cyc - start_cyc), 32'd155);
        check_bytes("bf0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver paired with `uart_tx`: it takes the asynchronous line `serial_in` (8N1, LSB first, idle high) and produces parallel bytes on a one-entry valid/ready output buffer for the CPU's MMIO or debug logic. Everything runs in the `clk` domain with a restartable bit-timing counter, so the block re-phases to each start edge. It flags framing errors and overruns as single-cycle pulses.

## Interface
- `BAUD_RATE`, default 115200, line bit rate.
- `CLOCK_SPEED`, default 100_000_000, `clk` frequency in Hz.
- Derived: `TICKS_PER_BIT = CLOCK_SPEED / BAUD_RATE` (integer divide), `HALF_BIT = TICKS_PER_BIT / 2`. Legal only if `TICKS_PER_BIT >= 4`.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `serial_in`  in  1  raw asynchronous RX line.
- `rx_ready`  in  1  consumer accepts `rx_data` this cycle.
- `rx_data`  out  8  received byte, stable while `rx_valid`=1.
- `rx_valid`  out  1  holding register full.
- `frame_error`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: good byte dropped because buffer full.

## Operation
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_error`=0, `overrun`=0, synchronizer flops=1, state IDLE, counters 0.
- `serial_in` passes through a 2-flop synchronizer. All decisions use the synchronized value `s_in`.
- IDLE:
  - `s_in`=0 → START, with bit counter loaded to `HALF_BIT-1`.
- START:
  - Counter decrements each cycle. At 0, sample `s_in`.
  - Sample 0 → DATA, counter=`TICKS_PER_BIT-1`, bit index=0.
  - Sample 1 → IDLE; the edge was a glitch and produces no outputs.
- DATA:
  - At each counter 0, shift `s_in` into bit [index] (LSB first) and reload `TICKS_PER_BIT-1`.
  - After index 7 → STOP.
- STOP:
  - At counter 0, sample `s_in`.
  - 1 → deliver the byte, then IDLE.
  - 0 → pulse `frame_error`, discard the byte, go to BREAK.
- BREAK:
  - Wait for `s_in`=1, then IDLE. A held-low line therefore yields exactly one `frame_error`.
- Delivery:
  - `rx_valid`=0, or `rx_valid`=1 with `rx_ready`=1 in the same cycle → load `rx_data`, `rx_valid`=1.
  - `rx_valid`=1 with `rx_ready`=0 → pulse `overrun`; the new byte is dropped and the held byte is kept.
- Handshake:
  - The consumer takes the byte on any cycle where `rx_valid`=1 and `rx_ready`=1.
  - If no delivery happens that cycle, `rx_valid` clears on the next edge.
  - `rx_ready` while `rx_valid`=0 has no effect.
- Reset asserted mid-frame: all state returns to reset values immediately and the partial byte is lost. After release, the receiver waits in IDLE for the next falling `s_in`.

## Timing
- Synchronizer latency: 2 cycles from pin to `s_in`.
- Start-bit check happens `HALF_BIT` cycles after `s_in` falls. Each data/stop sample follows at `TICKS_PER_BIT`-cycle spacing, so samples land mid-bit.
- `rx_valid`, `frame_error` and `overrun` assert on the edge after the stop-bit sample. The pulses last exactly 1 cycle.
- Byte latency from the start edge on the pin: 2 + `HALF_BIT` + 9·`TICKS_PER_BIT` + 1 cycles.
- Back-to-back frames (stop immediately followed by start) must be received. IDLE is re-entered before the next start edge reaches `s_in`.

## Structure
- Shared package `uart_pkg`:
  - the ticks-per-bit / half-bit computation, also used by `uart_tx`;
  - the frame constants: 8 data bits, 1 stop bit;
  - the RX state encoding (IDLE, START, DATA, STOP, BREAK).
- Sub-module `sync_2ff` (parameterised width, reset value 1) for the input synchronizer. Other blocks reuse it for async inputs.
- All other logic lives in `uart_rx`: FSM, bit counter, bit index, shift register, holding register.

## Test plan
Parameters `CLOCK_SPEED`=16, `BAUD_RATE`=1 (16 ticks/bit, half 8).
- Reset held with line high, then released → `rx_data`=0x00, `rx_valid`=0, and no pulses for 200 cycles.
- Drive 0x55 frame, `rx_ready`=1 → `rx_valid` high for 1 cycle with `rx_data`=0x55, exactly 2+8+144+1=155 cycles after the start edge.
- Low pulse of 4 cycles on an idle line → no `rx_valid`, no `frame_error`; a following 0x3C frame is received as 0x3C.
- Frame 0xA3 with stop bit 0, line then held low for 40 bit times, then high → exactly one `frame_error` pulse and `rx_valid` stays 0. The next 0xA3 frame delivers 0xA3.
- `rx_ready`=0, frames 0x12 then 0x34 back-to-back → `rx_data`=0x12, `rx_valid` stays 1, and one `overrun` pulse at the 0x34 stop. Asserting `rx_ready` for 1 cycle clears `rx_valid`.
- Reset pulsed after 4 data bits of 0xFF → outputs return to reset values. A subsequent 0xF0 frame is received as 0xF0 with no `frame_error`.
